data_cache: RTL

- Direct-mapped, write-back, write-allocate L1 data cache between the MA stage's load/store interface and a block-wide main data memory.
- Hits complete with zero stall.
- Misses raise BUSYWAIT, which the pipeline uses to freeze PC and all pipeline registers.
- Handles byte, half and word accesses using the same 2-bit READ/WRITE encoding the control unit emits.

---
 rtl/data_cache.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MA stage.
// Hits finish in the request cycle; misses hold BUSYWAIT until the block is filled.
module data_cache #(
  parameter int INDEX_BITS  = 3,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [1:0]   READ,
  input  logic [1:0]   WRITE,
  input  logic [31:0]  ADDR,
  input  logic [31:0]  DATA_IN,
  output logic [31:0]  DATA_OUT,
  output logic         BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDR,
  output logic [127:0] MEM_WRITEDATA,
  input  logic [127:0] MEM_READDATA,
  input  logic         MEM_BUSYWAIT
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  generate
    if (BLOCK_WORDS != 4) begin : g_bad_block
      $error("data_cache: BLOCK_WORDS must be 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_UPDATE    = 2'd3
  } state_e;

  // Handshake: a request (READ or WRITE non-zero) is accepted in the first
  // IDLE cycle with BUSYWAIT=0; the pipeline holds ADDR/READ/WRITE/DATA_IN
  // stable while BUSYWAIT=1. Toward memory, MEM_READ/MEM_WRITE stay high
  // until the first rising edge that sees MEM_BUSYWAIT=0.
  state_e                       state_q, state_d;
  logic [SETS-1:0]              valid_q, valid_d;
  logic [SETS-1:0]              dirty_q, dirty_d;
  logic [SETS-1:0][TAG_W-1:0]   tag_q, tag_d;
  logic [SETS-1:0][127:0]       data_q, data_d;
  logic [127:0]                 fill_q, fill_d;
  logic [31:0]                  data_out_q, data_out_d;
  logic                         mem_read_q, mem_read_d;
  logic                         mem_write_q, mem_write_d;
  logic [27:0]                  mem_addr_q, mem_addr_d;
  logic [127:0]                 mem_wdata_q, mem_wdata_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic [1:0]            wsel;
  logic                  hit;
  logic                  is_store;
  logic                  is_load;
  logic                  miss;
  logic [127:0]          cur_blk;
  logic [31:0]           cur_word;
  logic [31:0]           rd_data;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic [31:0]           merged_word;
  logic [127:0]          wr_blk;

  assign idx      = ADDR[3+INDEX_BITS:4];
  assign tag_in   = ADDR[31:4+INDEX_BITS];
  assign wsel     = ADDR[3:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag_in);
  assign is_store = (WRITE != 2'b00);
  assign is_load  = !is_store && (READ != 2'b00);
  assign miss     = (is_store || is_load) && !hit;
  assign cur_blk  = data_q[idx];
  assign cur_word = cur_blk[{wsel, 5'b00000} +: 32];

  // Load data is zero-extended and right-aligned; ADDR bits below the access size are ignored.
  always_comb begin
    rd_data = 32'b0;
    case (READ)
      2'b01:   rd_data = {24'b0, cur_word[{ADDR[1:0], 3'b000} +: 8]};
      2'b10:   rd_data = {16'b0, cur_word[{ADDR[1], 4'b0000} +: 16]};
      2'b11:   rd_data = cur_word;
      default: rd_data = 32'b0;
    endcase
  end

  // Store data arrives right-aligned; replicate it across lanes and enable the target lanes.
  always_comb begin
    be    = 4'b0000;
    wdata = DATA_IN;
    case (WRITE)
      2'b01: begin
        be    = 4'b0001 << ADDR[1:0];
        wdata = {4{DATA_IN[7:0]}};
      end
      2'b10: begin
        be    = ADDR[1] ? 4'b1100 : 4'b0011;
        wdata = {2{DATA_IN[15:0]}};
      end
      2'b11: begin
        be    = 4'b1111;
        wdata = DATA_IN;
      end
      default: begin
        be    = 4'b0000;
        wdata = DATA_IN;
      end
    endcase
  end

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged_word[b*8 +: 8] = wdata[b*8 +: 8];
    end
    wr_blk = cur_blk;
    wr_blk[{wsel, 5'b00000} +: 32] = merged_word;
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    fill_d      = fill_q;
    data_out_d  = data_out_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          if (valid_q[idx] && dirty_q[idx]) begin
            state_d     = S_WRITEBACK;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx};
            mem_wdata_d = cur_blk;
          end else begin
            state_d    = S_ALLOCATE;
            mem_read_d = 1'b1;
            mem_addr_d = ADDR[31:4];
          end
        end else if (is_store) begin
          data_d[idx]  = wr_blk;
          dirty_d[idx] = 1'b1;
        end else if (is_load) begin
          data_out_d = rd_data;
        end
      end
      S_WRITEBACK: begin
        if (!MEM_BUSYWAIT) begin
          state_d     = S_ALLOCATE;
          mem_write_d = 1'b0;
          mem_wdata_d = 128'b0;
          mem_read_d  = 1'b1;
          mem_addr_d  = ADDR[31:4];
        end
      end
      S_ALLOCATE: begin
        if (!MEM_BUSYWAIT) begin
          state_d    = S_UPDATE;
          fill_d     = MEM_READDATA;
          mem_read_d = 1'b0;
          mem_addr_d = 28'b0;
        end
      end
      S_UPDATE: begin
        state_d      = S_IDLE;
        data_d[idx]  = fill_q;
        tag_d[idx]   = tag_in;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      data_out_q  <= 32'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= 28'b0;
      mem_wdata_q <= 128'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      data_out_q  <= data_out_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
    fill_q <= fill_d;
  end

  // In reset the miss path must not raise BUSYWAIT, even with a request still applied.
  assign BUSYWAIT      = RESET && ((state_q != S_IDLE) || miss);
  assign DATA_OUT      = (RESET && (state_q == S_IDLE) && is_load && hit) ? rd_data : data_out_q;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDR      = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule
